// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVERSAMPLE     = 16;
  localparam int MID_START_TICK = 7;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer with a configurable reset value (used for rx, later CTS/RTS).
module uart_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ff <= {N{RST_VAL}};
    else         ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, DATA_BITS data bits LSB first, stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BIT_TICK = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 frame_err
);

  // s_cnt must reach STOP_BIT_TICK-1 and at least OVERSAMPLE-1.
  localparam int SW = ($clog2(STOP_BIT_TICK) < 4) ? 4 : $clog2(STOP_BIT_TICK);
  localparam int NW = $clog2(DATA_BITS);

  logic                 rx_s;
  rx_state_t            state, state_n;
  logic [SW-1:0]        s_cnt, s_cnt_n;
  logic [NW-1:0]        n_cnt, n_cnt_n;
  logic [DATA_BITS-1:0] b_reg, b_reg_n, dout_n;
  logic                 done_n, ferr_n;

  uart_sync #(.N(2), .RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (rx),
    .q      (rx_s)
  );

  // Next-state logic: timing advances only on tick, except the IDLE edge detect.
  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    b_reg_n = b_reg;
    dout_n  = dout;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt == SW'(MID_START_TICK)) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = IDLE;  // start bit gone by mid-bit: glitch
            end
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt == SW'(OVERSAMPLE - 1)) begin
            b_reg_n = {rx_s, b_reg[DATA_BITS-1:1]};
            s_cnt_n = '0;
            if (n_cnt == NW'(DATA_BITS - 1)) state_n = STOP;
            else                             n_cnt_n = n_cnt + NW'(1);
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt == SW'(STOP_BIT_TICK - 1)) begin
            dout_n  = b_reg;
            done_n  = 1'b1;
            ferr_n  = !rx_s;
            state_n = IDLE;
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, counters, shift register and registered strobes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      b_reg     <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      s_cnt     <= s_cnt_n;
      n_cnt     <= n_cnt_n;
      b_reg     <= b_reg_n;
      dout      <= dout_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 8N1 instance with tick every 2nd clk, 7-bit/2-stop instance with tick held high.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done, frame_err;

  logic       rx2 = 1'b1;
  logic [6:0] dout2;
  logic       rx_done2, frame_err2;

  int checks = 0;
  int errors = 0;

  logic [8:0] got_q[$];   // {frame_err, dout} per rx_done
  logic       stray_ferr = 1'b0;
  logic [7:0] last_byte = 8'h00;  // model: last delivered byte

  uart_rx #(.DATA_BITS(8), .STOP_BIT_TICK(16)) dut (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx),
    .dout(dout), .rx_done(rx_done), .frame_err(frame_err)
  );

  uart_rx #(.DATA_BITS(7), .STOP_BIT_TICK(32)) dut2 (
    .clk(clk), .arst_n(arst_n), .tick(1'b1), .rx(rx2),
    .dout(dout2), .rx_done(rx_done2), .frame_err(frame_err2)
  );

  always #5 clk = ~clk;

  // tick high on every other posedge
  always @(negedge clk) tick = ~tick;

  // monitor: collect every delivered frame on the opposite edge
  always @(negedge clk) begin
    if (rx_done) got_q.push_back({frame_err, dout});
    if (frame_err && !rx_done) stray_ferr = 1'b1;
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    @(negedge clk);
  endtask

  // 16 ticks per bit, LSB first. A bad stop bit is held low only past the
  // receiver's stop sample so the tail is not taken as a new start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      rx = 1'b0;
      wait_ticks(10);
      rx = 1'b1;
      wait_ticks(22);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    checks++;
    if (rx_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got %b%b want 00", rx_done, frame_err);
    end
    checks++;
    if (dout2 !== 7'h00 || rx_done2 !== 1'b0) begin
      errors++; $display("FAIL reset_dut2 got %h/%b want 00/0", dout2, rx_done2);
    end
    arst_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    got_q.delete();
    send_frame(8'hCB, 1'b1);
    wait_ticks(4);
    last_byte = 8'hCB;
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== {1'b0, 8'hCB}) begin errors++; $display("FAIL basic_data got %h want 0cb", got_q[0]); end
    end
  endtask

  task automatic test_glitch();
    got_q.delete();
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(200);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", got_q.size()); end
    checks++;
    if (dout !== last_byte) begin errors++; $display("FAIL glitch_dout got %h want %h", dout, last_byte); end
  endtask

  task automatic test_frame_err();
    got_q.delete();
    send_frame(8'h55, 1'b0);
    wait_ticks(4);
    last_byte = 8'h55;
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== {1'b1, 8'h55}) begin errors++; $display("FAIL ferr_data got %h want 155", got_q[0]); end
    end
    checks++;
    if (stray_ferr !== 1'b0) begin errors++; $display("FAIL ferr_alone got %b want 0", stray_ferr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'hA5;
    got_q.delete();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    wait_ticks(4);
    last_byte = 8'hA5;
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", got_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== {1'b0, exp[i]}) begin
          errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[i], {1'b0, exp[i]});
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    d = 8'h3C;
    got_q.delete();
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = d[4];
    wait_ticks(8);
    arst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL abort_dout got %h want 00", dout); end
    arst_n = 1'b1;
    wait_ticks(200);
    last_byte = 8'h00;
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", got_q.size()); end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL abort_dout_hold got %h want 00", dout); end
    send_frame(8'h81, 1'b1);
    wait_ticks(4);
    last_byte = 8'h81;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 8'h81}) begin
      errors++; $display("FAIL abort_next got n=%0d %h want n=1 081", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [7:0] d;
    logic       ok;
    got_q.delete();
    for (int f = 0; f < 12; f++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      exp_q.push_back({!ok, d});
      send_frame(d, ok);
      if ($urandom_range(0, 1) == 1) wait_ticks($urandom_range(1, 5));
    end
    wait_ticks(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_pulses got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // tick always high: latency in clks = 2 sync + 1 edge detect + 8 half start
  // + 7 bits * 16 + 32 stop ticks, i.e. 32 after the last data sample.
  task automatic test_wide();
    logic [6:0] d;
    int lat, pulses;
    logic [6:0] got;
    logic fe;
    d = 7'h5A; lat = -1; pulses = 0; got = '0; fe = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rx_done2) begin
        pulses++;
        if (lat < 0) lat = k;
        got = dout2;
        fe  = frame_err2;
      end
      if (k < 16)       rx2 = 1'b0;
      else if (k < 128) rx2 = d[3'((k / 16) - 1)];
      else              rx2 = 1'b1;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL wide_pulses got %0d want 1", pulses); end
    checks++;
    if (got !== 7'h5A || fe !== 1'b0) begin errors++; $display("FAIL wide_data got %h/%b want 5a/0", got, fe); end
    checks++;
    if (lat != 2 + 1 + 8 + 7 * 16 + 32) begin
      errors++; $display("FAIL wide_latency got %0d want %0d", lat, 2 + 1 + 8 + 7 * 16 + 32);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for the MMIO UART subsystem. It is the receive-side counterpart of the existing transmitter and shares its 16x-oversampling `tick` from the common baud generator. The block recovers LSB-first frames (start bit, DATA_BITS data bits, one stop bit) from the `rx` pin. It presents the received byte on `dout` with a one-cycle `rx_done` strobe to the UART register/FIFO layer.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `STOP_BIT_TICK`, 16: ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits).
- `clk`  in  1  system clock; the only clock.
- `arst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  single-cycle enable at 16x the baud rate; all bit timing advances only on cycles where `tick` = 1.
- `rx`  in  1  asynchronous serial input; idles high.
- `dout`  out  DATA_BITS  last received data word; holds its value until the next frame completes.
- `rx_done`  out  1  one-cycle pulse when a frame completes.
- `frame_err`  out  1  one-cycle pulse, coincident with `rx_done`, when the sampled stop bit is 0.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, STOP. The FSM uses a 4-bit tick counter `s_cnt`, a bit counter `n_cnt` of width clog2(DATA_BITS), and a shift register `b_reg` of width DATA_BITS.
- **IDLE:** when `rx_s` = 0, go to START and clear `s_cnt`. This transition does not require `tick`.
- **START:** on each tick, increment `s_cnt`. When a tick arrives with `s_cnt` = 7 (mid start bit):
  - if `rx_s` = 0, go to DATA and clear `s_cnt` and `n_cnt`;
  - if `rx_s` = 1, treat it as a false start (glitch) and return to IDLE with no output.
- **DATA:** on each tick, increment `s_cnt`. When a tick arrives with `s_cnt` = 15:
  - shift right: `b_reg` <= {`rx_s`, `b_reg`[DATA_BITS-1:1]}, so the LSB is received first;
  - clear `s_cnt`;
  - if `n_cnt` = DATA_BITS-1, go to STOP; otherwise increment `n_cnt`.
- **STOP:** on each tick, increment `s_cnt`. When a tick arrives with `s_cnt` = STOP_BIT_TICK-1:
  - load `dout` <= `b_reg`;
  - pulse `rx_done`;
  - pulse `frame_err` if `rx_s` = 0;
  - return to IDLE.
- A frame with a framing error is still delivered on `dout`. Software decides whether to discard it.
- `s_cnt` width must hold STOP_BIT_TICK-1. Size it as clog2(STOP_BIT_TICK) bits, with a minimum of 4.

## Timing
- Reset values: `dout` = 0, `rx_done` = 0, `frame_err` = 0, FSM = IDLE, all counters = 0, `b_reg` = 0, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately: no `rx_done`, and `dout` returns to 0.
- `rx_done` and `frame_err` are registered. They are high for exactly the one `clk` cycle after the edge that processes the final stop tick.
- Input latency: 2 `clk` cycles through the synchronizer before the FSM sees an edge.
- The start edge is detected at most 1 tick period late. The worst-case sample point is therefore mid-bit ± 1/16 bit.
- Back-to-back frames: IDLE accepts a new falling edge on the cycle after the STOP→IDLE transition. No idle ticks are required between frames beyond the stop bit.
- `tick` held high continuously is legal; the FSM then advances once per `clk`.
- A `tick` in the same cycle as the IDLE→START transition is not counted.

## Structure
- `uart_pkg` holds the shared UART definitions:
  - `rx_state_t` enum {IDLE, START, DATA, STOP};
  - `OVERSAMPLE` = 16;
  - `MID_START_TICK` = 7.
- The transmitter migrates to `uart_pkg` when it is next touched.
- Sub-module `uart_sync`: parameterizable N-flop synchronizer (default 2) with a configurable reset value. It is reused later for CTS/RTS.
- FSM, counters and shift register are a single always_ff block with a separate next-state always_comb.

## Test plan
- `tick` every 2nd `clk`; drive frame 0xCB LSB-first with 16 ticks per bit and a stop bit of 1 → exactly one `rx_done` pulse, `dout` = 8'hCB, `frame_err` = 0.
- `rx` low for 4 ticks then high (glitch) → FSM returns to IDLE; no `rx_done` within 200 ticks; `dout` unchanged.
- Frame 0x55 with the stop bit driven 0 → `rx_done` and `frame_err` pulse in the same cycle; `dout` = 8'h55.
- Frames 0x00, 0xFF and 0xA5 back-to-back with no idle gap → three `rx_done` pulses, with `dout` sequence 00, FF, A5.
- Assert `arst_n` = 0 during data bit 4 of 0x3C, release, then send 0x81 → no pulse for the aborted frame; `dout` = 0 after reset, then 8'h81.
- DATA_BITS = 7, STOP_BIT_TICK = 32: frame 7'h5A with 2 stop bits → `dout` = 7'h5A; `rx_done` pulses 32 ticks after the last data sample.
